vec_id_stage: RTL

- Parametrised vector decode stage. It replaces the fixed 8-register, always-advancing decoder.
- Holds one instruction in a valid/ready pipeline slot and decodes RVV OP-V fields for a configurable register-file size.
- Tracks in-flight destination registers in a scoreboard and stalls issue on RAW/WAW hazards until writeback clears them.
- Sits between the fetch stage and the vector execute stage.

---
 rtl/vec_id_stage_pkg.sv | 43 ++++
 rtl/vec_id_stage_vreg_scoreboard.sv | 66 ++++++
 rtl/vec_id_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vec_id_stage_pkg.sv
// ---------------------------------------------------------------------------
// vec_id_stage_pkg
//   Shared constants and helpers for the vector decode stage: the RVV OP-V
//   major opcode, instruction field positions and a field-unpacking helper.
// ---------------------------------------------------------------------------
package vec_id_stage_pkg;

   localparam logic [6:0] OP_VECTOR = 7'b1010111;

   localparam int VD_LSB       = 7;
   localparam int VS1_LSB      = 15;
   localparam int VS2_LSB      = 20;
   localparam int FUNCT3_LSB   = 12;
   localparam int FUNCT6_LSB   = 26;
   localparam int VREG_FIELD_W = 5;

   // Raw OP-V fields at full encoding width, before any truncation.
   typedef struct packed {
      logic [5:0]              funct6;
      logic [VREG_FIELD_W-1:0] vs2;
      logic [VREG_FIELD_W-1:0] vs1;
      logic [2:0]              funct3;
      logic [VREG_FIELD_W-1:0] vd;
      logic [6:0]              opcode;
   } opv_fields_t;

   function automatic opv_fields_t unpack_opv(input logic [31:0] instr);
      opv_fields_t f;
      f.opcode = instr[6:0];
      f.vd     = instr[VD_LSB     +: VREG_FIELD_W];
      f.funct3 = instr[FUNCT3_LSB +: 3];
      f.vs1    = instr[VS1_LSB    +: VREG_FIELD_W];
      f.vs2    = instr[VS2_LSB    +: VREG_FIELD_W];
      f.funct6 = instr[FUNCT6_LSB +: 6];
      return f;
   endfunction

   // True when an encoded register index names a register that does not exist.
   function automatic logic idx_oob(input logic [VREG_FIELD_W-1:0] idx, input int nregs);
      return int'(idx) >= nregs;
   endfunction

endpackage

// File: rtl/vec_id_stage_vreg_scoreboard.sv
// ---------------------------------------------------------------------------
// vreg_scoreboard
//   One pending bit per architectural vector register. A bit is set when a
//   writer issues and cleared when its writeback completes; when both hit the
//   same register in one cycle the set wins (the new writer is still pending).
//   Out-of-range clear indices are ignored.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   set_en, set_idx         mark a register pending
//   clr_en, clr_idx         mark a register written back
//   rd_idx0..2 / rd_busy0..2  hazard lookup ports
//   busy                    all pending bits
// ---------------------------------------------------------------------------
module vreg_scoreboard #(
   parameter  int NUM_VREGS = 8,
   localparam int VREG_AW   = $clog2(NUM_VREGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 set_en,
   input  logic [VREG_AW-1:0]   set_idx,
   input  logic                 clr_en,
   input  logic [VREG_AW-1:0]   clr_idx,
   input  logic [VREG_AW-1:0]   rd_idx0,
   input  logic [VREG_AW-1:0]   rd_idx1,
   input  logic [VREG_AW-1:0]   rd_idx2,
   output logic                 rd_busy0,
   output logic                 rd_busy1,
   output logic                 rd_busy2,
   output logic [NUM_VREGS-1:0] busy
);

   logic [NUM_VREGS-1:0] busy_q;

   // NOTE: the pending bits are architectural state and must come out of
   // reset cleared, so this small register file is reset unlike a data RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NUM_VREGS; i++) begin
            if (set_en && int'(set_idx) == i)
               busy_q[i] <= 1'b1;
            else if (clr_en && int'(clr_idx) == i)
               busy_q[i] <= 1'b0;
         end
      end
   end

   // Compare-based lookup so an index beyond NUM_VREGS reads as not busy.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      rd_busy0 = 1'b0;
      rd_busy1 = 1'b0;
      rd_busy2 = 1'b0;
      for (int i = 0; i < NUM_VREGS; i++) begin
         if (int'(rd_idx0) == i) rd_busy0 = busy_q[i];
         if (int'(rd_idx1) == i) rd_busy1 = busy_q[i];
         if (int'(rd_idx2) == i) rd_busy2 = busy_q[i];
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/vec_id_stage.sv
// ---------------------------------------------------------------------------
// vec_id_stage
//   Vector decode stage between fetch and vector execute. Holds one
//   instruction in a valid/ready slot, decodes its OP-V fields combinationally
//   and withholds issue while any register it touches has a pending write.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready/in_instr  upstream handshake and raw instruction
//   out_valid/out_ready         downstream issue handshake
//   is_vector, illegal, vd, vs1, vs2, reg_write, alu_op, funct6
//                               decoded fields of the held instruction
//   wb_valid, wb_vd             writeback completion
//   flush                       discard the held instruction
//   busy_mask                   scoreboard pending bits
//   stall_cycles                saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module vec_id_stage
   import vec_id_stage_pkg::*;
#(
   parameter  int NUM_VREGS = 8,
   parameter  int STALL_CW  = 16,
   localparam int VREG_AW   = $clog2(NUM_VREGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 is_vector,
   output logic                 illegal,
   output logic [VREG_AW-1:0]   vd,
   output logic [VREG_AW-1:0]   vs1,
   output logic [VREG_AW-1:0]   vs2,
   output logic                 reg_write,
   output logic [2:0]           alu_op,
   output logic [5:0]           funct6,
   input  logic                 wb_valid,
   input  logic [VREG_AW-1:0]   wb_vd,
   input  logic                 flush,
   output logic [NUM_VREGS-1:0] busy_mask,
   output logic [STALL_CW-1:0]  stall_cycles
);

   logic                held;
   logic                ready_en;   // keeps in_ready low until one cycle after reset
   logic [31:0]         instr_q;
   logic [31:0]         instr_eff;
   opv_fields_t         f;
   logic                hazard;
   logic                issue;
   logic                accept;
   logic                busy_vd, busy_vs1, busy_vs2;
   logic [STALL_CW-1:0] stall_q;

   // An empty slot decodes as all-zero, which is not an OP-V opcode, so every
   // decoded output falls to 0 without per-output gating.
   assign instr_eff = held ? instr_q : '0;
   assign f         = unpack_opv(instr_eff);

   assign is_vector = (f.opcode == OP_VECTOR);
   assign illegal   = is_vector && (idx_oob(f.vd, NUM_VREGS) ||
                                    idx_oob(f.vs1, NUM_VREGS) ||
                                    idx_oob(f.vs2, NUM_VREGS));
   assign reg_write = is_vector && !illegal;
   assign vd        = f.vd[VREG_AW-1:0];
   assign vs1       = f.vs1[VREG_AW-1:0];
   assign vs2       = f.vs2[VREG_AW-1:0];
   assign alu_op    = f.funct3;
   assign funct6    = f.funct6;

   // Only legal vector writers consult the scoreboard.
   assign hazard    = held && reg_write && (busy_vs1 || busy_vs2 || busy_vd);

   // Flush suppresses the handshake so a discarded instruction can never
   // appear to issue in the same cycle it is dropped.
   assign out_valid = held && !hazard && !flush;
   assign issue     = out_valid && out_ready;
   assign in_ready  = ready_en && !flush && (!held || issue);
   assign accept    = in_valid && in_ready;

   vreg_scoreboard #(
      .NUM_VREGS (NUM_VREGS)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue && reg_write),
      .set_idx  (vd),
      .clr_en   (wb_valid),
      .clr_idx  (wb_vd),
      .rd_idx0  (vs1),
      .rd_idx1  (vs2),
      .rd_idx2  (vd),
      .rd_busy0 (busy_vs1),
      .rd_busy1 (busy_vs2),
      .rd_busy2 (busy_vd),
      .busy     (busy_mask)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held     <= 1'b0;
         ready_en <= 1'b0;
         instr_q  <= '0;
         stall_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop here samples the
         // pre-edge values of held/issue/accept, independent of statement order.
         ready_en <= 1'b1;
         if (flush) begin
            held <= 1'b0;
         end else if (accept) begin
            held    <= 1'b1;
            instr_q <= in_instr;
         end else if (issue) begin
            held <= 1'b0;
         end

         if (hazard && stall_q != '1)
            stall_q <= stall_q + STALL_CW'(1);
      end
   end

   assign stall_cycles = stall_q;

endmodule
